// File: rtl/csi_rx_packet_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : csi_rx_packet_sequencer
// Description : CSI-2 packet-level controller after the D-PHY word combiner.
//               Arms sync detection, parses packet headers, emits short-packet
//               sync events and a byte-qualified payload stream, and ends
//               each packet with a packet_done pulse to the combiner.
//               Optional header ECC check: define CSI_RX_ECC_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module csi_rx_packet_sequencer #(
    parameter logic [15:0] MAX_WC = 16'hFFFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] word_in,
    input  logic        word_enable,
    input  logic        word_frame,
    output logic        wait_for_sync,
    output logic        packet_done,
    output logic [1:0]  vc,
    output logic [5:0]  dt,
    output logic [15:0] wc,
    output logic        frame_start,
    output logic        frame_end,
    output logic        line_start,
    output logic        line_end,
    output logic [31:0] payload_data,
    output logic [3:0]  payload_keep,
    output logic        payload_valid,
    output logic        payload_last,
    output logic        pkt_error
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HEADER  = 2'd1,
        S_PAYLOAD = 2'd2,
        S_DRAIN   = 2'd3
    } state_t;

    state_t      state;
    logic        frame_prev;
    logic [17:0] total_words;
    logic [17:0] data_words;
    logic [17:0] word_index;

    // Header fields decoded straight from the incoming word
    logic [17:0] hdr_wc;
    logic        hdr_long;
    logic        hdr_reject;
    logic [3:0]  keep_next;
    logic [19:0] byte_base;
    logic [19:0] wc_ext;

    assign hdr_wc    = {2'b00, word_in[23:8]};
    assign hdr_long  = (word_in[5:4] != 2'b00);
    assign byte_base = {word_index, 2'b00};
    assign wc_ext    = {4'b0000, wc};

`ifdef CSI_RX_ECC_CHECK_EN
    // Hamming parity over the 24 header data bits; one mask per ECC bit
    logic [5:0] ecc_calc;
    logic       unused_bits;
    assign ecc_calc[0] = ^(word_in[23:0] & 24'hF12CB7);
    assign ecc_calc[1] = ^(word_in[23:0] & 24'hF2555B);
    assign ecc_calc[2] = ^(word_in[23:0] & 24'h749A6D);
    assign ecc_calc[3] = ^(word_in[23:0] & 24'hB8E38E);
    assign ecc_calc[4] = ^(word_in[23:0] & 24'hDF03F0);
    assign ecc_calc[5] = ^(word_in[23:0] & 24'hEFFC00);
    assign unused_bits = ^word_in[31:30];
    assign hdr_reject  = (ecc_calc != word_in[29:24]) ||
                         (hdr_long && (hdr_wc > {2'b00, MAX_WC}));
`else
    logic unused_bits;
    assign unused_bits = ^word_in[31:24];
    assign hdr_reject  = hdr_long && (hdr_wc > {2'b00, MAX_WC});
`endif

    // A byte of the current word is valid while its absolute byte offset is below wc
    for (genvar b = 0; b < 4; b++) begin : g_keep
        assign keep_next[b] = ((byte_base + 20'(b)) < wc_ext);
    end

    // Packet state machine with all outputs registered
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= S_IDLE;
            frame_prev    <= 1'b0;
            total_words   <= '0;
            data_words    <= '0;
            word_index    <= '0;
            wait_for_sync <= 1'b1;
            packet_done   <= 1'b0;
            vc            <= '0;
            dt            <= '0;
            wc            <= '0;
            frame_start   <= 1'b0;
            frame_end     <= 1'b0;
            line_start    <= 1'b0;
            line_end      <= 1'b0;
            payload_data  <= '0;
            payload_keep  <= '0;
            payload_valid <= 1'b0;
            payload_last  <= 1'b0;
            pkt_error     <= 1'b0;
        end else begin
            // Pulses are single-cycle; a stalled cycle never re-issues one
            packet_done   <= 1'b0;
            frame_start   <= 1'b0;
            frame_end     <= 1'b0;
            line_start    <= 1'b0;
            line_end      <= 1'b0;
            payload_valid <= 1'b0;
            payload_last  <= 1'b0;
            pkt_error     <= 1'b0;
            if (enable) begin
                frame_prev <= word_frame;
                case (state)
                    S_IDLE: begin
                        if (word_frame && !frame_prev) begin
                            state         <= S_HEADER;
                            wait_for_sync <= 1'b0;
                        end
                    end
                    S_HEADER: begin
                        if (!word_frame) begin
                            pkt_error     <= 1'b1;
                            wait_for_sync <= 1'b1;
                            state         <= S_IDLE;
                        end else if (word_enable) begin
                            dt <= word_in[5:0];
                            vc <= word_in[7:6];
                            wc <= word_in[23:8];
                            if (hdr_reject) begin
                                pkt_error   <= 1'b1;
                                packet_done <= 1'b1;
                                state       <= S_DRAIN;
                            end else if (!hdr_long) begin
                                frame_start <= (word_in[5:0] == 6'h00);
                                frame_end   <= (word_in[5:0] == 6'h01);
                                line_start  <= (word_in[5:0] == 6'h02);
                                line_end    <= (word_in[5:0] == 6'h03);
                                packet_done <= 1'b1;
                                state       <= S_DRAIN;
                            end else begin
                                data_words  <= (hdr_wc + 18'd3) >> 2;
                                total_words <= (hdr_wc + 18'd5) >> 2;
                                word_index  <= '0;
                                state       <= S_PAYLOAD;
                            end
                        end
                    end
                    S_PAYLOAD: begin
                        if (!word_frame) begin
                            pkt_error     <= 1'b1;
                            wait_for_sync <= 1'b1;
                            state         <= S_IDLE;
                        end else if (word_enable) begin
                            if (word_index < data_words) begin
                                payload_valid <= 1'b1;
                                payload_data  <= word_in;
                                payload_keep  <= keep_next;
                                payload_last  <= (word_index == data_words - 18'd1);
                            end
                            if (word_index == total_words - 18'd1) begin
                                packet_done <= 1'b1;
                                state       <= S_DRAIN;
                            end
                            word_index <= word_index + 18'd1;
                        end
                    end
                    S_DRAIN: begin
                        if (!word_frame) begin
                            wait_for_sync <= 1'b1;
                            state         <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_csi_rx_packet_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_csi_rx_packet_sequencer
// Description : Self-checking bench for csi_rx_packet_sequencer. Packets are
//               described by (dt, vc, wc); expected strobes come from the
//               packet rules evaluated arithmetically per payload word.
//               Define CSI_RX_ECC_CHECK_EN to also exercise header ECC.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csi_rx_packet_sequencer;

    localparam int MAXWC = 64;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] word_in;
    logic        word_enable;
    logic        word_frame;
    logic        wait_for_sync;
    logic        packet_done;
    logic [1:0]  vc;
    logic [5:0]  dt;
    logic [15:0] wc;
    logic        frame_start, frame_end, line_start, line_end;
    logic [31:0] payload_data;
    logic [3:0]  payload_keep;
    logic        payload_valid;
    logic        payload_last;
    logic        pkt_error;

    csi_rx_packet_sequencer #(.MAX_WC(16'(MAXWC))) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .word_in(word_in), .word_enable(word_enable), .word_frame(word_frame),
        .wait_for_sync(wait_for_sync), .packet_done(packet_done),
        .vc(vc), .dt(dt), .wc(wc),
        .frame_start(frame_start), .frame_end(frame_end),
        .line_start(line_start), .line_end(line_end),
        .payload_data(payload_data), .payload_keep(payload_keep),
        .payload_valid(payload_valid), .payload_last(payload_last),
        .pkt_error(pkt_error)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Expected values of every output
    logic        e_wfs, e_done, e_err, e_fs, e_fe, e_ls, e_le, e_valid, e_last;
    logic [1:0]  e_vc;
    logic [5:0]  e_dt;
    logic [15:0] e_wc;
    logic [31:0] e_data;
    logic [3:0]  e_keep;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".wait_for_sync"}, 32'(wait_for_sync), 32'(e_wfs));
        chk({tag, ".packet_done"},   32'(packet_done),   32'(e_done));
        chk({tag, ".pkt_error"},     32'(pkt_error),     32'(e_err));
        chk({tag, ".vc"},            32'(vc),            32'(e_vc));
        chk({tag, ".dt"},            32'(dt),            32'(e_dt));
        chk({tag, ".wc"},            32'(wc),            32'(e_wc));
        chk({tag, ".frame_start"},   32'(frame_start),   32'(e_fs));
        chk({tag, ".frame_end"},     32'(frame_end),     32'(e_fe));
        chk({tag, ".line_start"},    32'(line_start),    32'(e_ls));
        chk({tag, ".line_end"},      32'(line_end),      32'(e_le));
        chk({tag, ".payload_valid"}, 32'(payload_valid), 32'(e_valid));
        chk({tag, ".payload_last"},  32'(payload_last),  32'(e_last));
        chk({tag, ".payload_data"},  payload_data,       e_data);
        chk({tag, ".payload_keep"},  32'(payload_keep),  32'(e_keep));
    endtask

    task automatic clr_pulses();
        e_done = 0; e_err = 0; e_fs = 0; e_fe = 0; e_ls = 0; e_le = 0;
        e_valid = 0; e_last = 0;
    endtask

    task automatic exp_reset();
        clr_pulses();
        e_wfs = 1; e_vc = 0; e_dt = 0; e_wc = 0; e_data = 0; e_keep = 0;
    endtask

    // Drive one clock cycle, then sample just after the edge
    task automatic step(input logic we, input logic fr, input logic [31:0] w);
        word_enable = we;
        word_frame  = fr;
        word_in     = w;
        @(posedge clock);
        #1;
    endtask

    // CSI-2 header ECC: parity bit k covers the data bits set in its mask
    function automatic logic [5:0] ecc6(input logic [23:0] d);
        logic [23:0] m [6];
        logic [5:0]  e;
        m[0] = 24'hF12CB7; m[1] = 24'hF2555B; m[2] = 24'h749A6D;
        m[3] = 24'hB8E38E; m[4] = 24'hDF03F0; m[5] = 24'hEFFC00;
        for (int k = 0; k < 6; k++) e[k] = ^(d & m[k]);
        return e;
    endfunction

    function automatic logic [31:0] make_hdr(input logic [5:0] pdt, input logic [1:0] pvc,
                                             input logic [15:0] pwc);
        logic [23:0] d;
        d = {pwc, pvc, pdt};
        return {2'b00, ecc6(d), d};
    endfunction

    // Bytes left in the packet at word k decide which lanes are valid
    function automatic logic [3:0] keep_of(input int pwc, input int k);
        int rem;
        rem = pwc - 4 * k;
        if (rem >= 4) return 4'hF;
        return 4'((1 << rem) - 1);
    endfunction

    // Send a complete packet and check every cycle of it
    task automatic do_packet(input logic [5:0] pdt, input logic [1:0] pvc,
                             input logic [15:0] pwc, input logic bad_ecc,
                             input logic stall);
        logic [31:0] hdr, w;
        int d, t;
        logic is_long;
        hdr = make_hdr(pdt, pvc, pwc);
        if (bad_ecc) hdr[29:24] = 6'h00;
        is_long = 0;
        clr_pulses();
        step(0, 0, $urandom);
        check_all("idle");
        step(1, 0, $urandom);
        check_all("idle_word");
        step(0, 1, $urandom);
        e_wfs = 0;
        check_all("frame_rise");
        if ($urandom_range(0, 1) == 1) begin
            step(0, 1, $urandom);
            check_all("hdr_gap");
        end
        step(1, 1, hdr);
        e_vc = pvc; e_dt = pdt; e_wc = pwc;
        if (bad_ecc || (pdt >= 6'h10 && int'(pwc) > MAXWC)) begin
            e_err = 1; e_done = 1;
        end else if (pdt < 6'h10) begin
            e_fs = (pdt == 6'h00); e_fe = (pdt == 6'h01);
            e_ls = (pdt == 6'h02); e_le = (pdt == 6'h03);
            e_done = 1;
        end else begin
            is_long = 1;
        end
        check_all("header");
        if (is_long) begin
            d = (int'(pwc) + 3) / 4;
            t = (int'(pwc) + 2 + 3) / 4;
            if (stall) begin
                clr_pulses();
                enable = 0;
                step(1, 1, $urandom);
                check_all("stall0");
                step(1, 1, $urandom);
                check_all("stall1");
                enable = 1;
            end
            for (int k = 0; k < t; k++) begin
                clr_pulses();
                if ($urandom_range(0, 3) == 0) begin
                    step(0, 1, $urandom);
                    check_all("pay_gap");
                end
                w = $urandom;
                step(1, 1, w);
                if (k < d) begin
                    e_valid = 1; e_data = w; e_keep = keep_of(int'(pwc), k);
                    e_last = (k == d - 1);
                end
                e_done = (k == t - 1);
                check_all("payload");
            end
        end
        clr_pulses();
        step(0, 0, $urandom);
        e_wfs = 1;
        check_all("drain_exit");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] w;
        reset = 1; enable = 1; word_in = 0; word_enable = 0; word_frame = 0;
        exp_reset();
        step(0, 0, 0);
        step(0, 0, 0);
        check_all("reset");
        reset = 0;

        // Short packets: FS with zero header, then each event type
        do_packet(6'h00, 2'd0, 16'h0000, 0, 0);
        do_packet(6'h01, 2'd1, 16'h0005, 0, 0);
        do_packet(6'h02, 2'd2, 16'h0007, 0, 0);
        do_packet(6'h03, 2'd3, 16'h0009, 0, 0);
        do_packet(6'h07, 2'd1, 16'h0030, 0, 0);
        // Long packet word-count boundaries
        do_packet(6'h2A, 2'd0, 16'd6, 0, 0);
        do_packet(6'h2A, 2'd1, 16'd4, 0, 0);
        do_packet(6'h2A, 2'd2, 16'd0, 0, 0);
        do_packet(6'h2B, 2'd3, 16'd1, 0, 1);
        do_packet(6'h2B, 2'd0, 16'(MAXWC), 0, 0);
        do_packet(6'h2B, 2'd1, 16'(MAXWC + 1), 0, 0);

        // Abort in PAYLOAD: frame drops after 1 of 3 payload words
        clr_pulses();
        step(0, 0, 0);
        check_all("ab_idle");
        step(0, 1, 0);
        e_wfs = 0;
        check_all("ab_rise");
        step(1, 1, make_hdr(6'h2A, 2'd1, 16'd12));
        e_vc = 1; e_dt = 6'h2A; e_wc = 16'd12;
        check_all("ab_header");
        w = $urandom;
        step(1, 1, w);
        e_valid = 1; e_data = w; e_keep = 4'hF;
        check_all("ab_word");
        clr_pulses();
        step(0, 0, $urandom);
        e_err = 1; e_wfs = 1;
        check_all("ab_drop");
        clr_pulses();
        step(0, 0, $urandom);
        check_all("ab_after");

        // Abort in HEADER
        step(0, 1, 0);
        e_wfs = 0;
        check_all("abh_rise");
        step(0, 0, 0);
        e_err = 1; e_wfs = 1;
        check_all("abh_drop");
        clr_pulses();

        // Reset mid-PAYLOAD
        step(0, 1, 0);
        e_wfs = 0;
        check_all("rs_rise");
        step(1, 1, make_hdr(6'h2B, 2'd2, 16'd40));
        e_vc = 2; e_dt = 6'h2B; e_wc = 16'd40;
        check_all("rs_header");
        w = $urandom;
        step(1, 1, w);
        e_valid = 1; e_data = w; e_keep = 4'hF;
        check_all("rs_word");
        reset = 1;
        step(1, 0, $urandom);
        exp_reset();
        check_all("rs_reset");
        reset = 0;

`ifdef CSI_RX_ECC_CHECK_EN
        // Header 0x00000100 carries ECC field 0, which does not match its data
        do_packet(6'h00, 2'd0, 16'h0001, 1, 0);
        do_packet(6'h2C, 2'd3, 16'd9, 1, 0);
`endif

        // Randomized packets
        for (int n = 0; n < 30; n++) begin
            logic [5:0] rdt;
            rdt = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 15))
                                              : 6'($urandom_range(16, 63));
            do_packet(rdt, 2'($urandom_range(0, 3)), 16'($urandom_range(0, MAXWC)),
                      0, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/csi_rx_packet_sequencer.md
# csi_rx_packet_sequencer

Packet-level controller sitting directly after the D-PHY word combiner. It arms the combiner for sync (`wait_for_sync`), parses the 32-bit CSI-2 packet header, counts payload and CRC words, and terminates each packet with a `packet_done` pulse back to the combiner. It emits decoded short-packet sync events and a byte-qualified payload stream for the pixel unpacker.

## Interface
Parameters:
- `MAX_WC`, default 16'hFFFF: largest accepted long-packet word count. Larger headers are treated as errors.

Ports:
- `clock`  in  1  byte clock, shared with the combiner
- `reset`  in  1  synchronous, active-high
- `enable`  in  1  clock enable; all state holds while low
- `word_in`  in  32  combiner word; byte 0 is `[7:0]`
- `word_enable`  in  1  `word_in` valid this cycle
- `word_frame`  in  1  combiner packet-in-progress flag
- `wait_for_sync`  out  1  arms combiner sync detection
- `packet_done`  out  1  one-cycle end-of-packet pulse to the combiner
- `vc`  out  2  virtual channel of the current packet
- `dt`  out  6  data type of the current packet
- `wc`  out  16  word count / short-packet data field
- `frame_start`, `frame_end`, `line_start`, `line_end`  out  1 each  short-packet event pulses
- `payload_data`  out  32  payload word
- `payload_keep`  out  4  per-byte valid for `payload_data`
- `payload_valid`  out  1  payload word strobe
- `payload_last`  out  1  final payload word of the packet
- `pkt_error`  out  1  one-cycle pulse on a truncated or rejected packet

## Operation
- States: IDLE, HEADER, PAYLOAD, DRAIN.
- **IDLE:** `wait_for_sync`=1. Rising `word_frame` moves the block to HEADER.
- **HEADER:** on the first `word_enable`, latch `dt`=`word_in[5:0]`, `vc`=`word_in[7:6]`, `wc`=`word_in[23:8]`.
  - dt < 0x10 (short packet): pulse the matching event (0x00 FS, 0x01 FE, 0x02 LS, 0x03 LE; 0x04–0x0F no event) and `packet_done`, then go to DRAIN.
  - dt ≥ 0x10 (long packet): load counters and go to PAYLOAD.
  - wc > `MAX_WC`: pulse `pkt_error` and `packet_done`, then go to DRAIN.
- **Counters (18-bit arithmetic):**
  - Total words T = (wc+5)>>2, covering payload plus 2 CRC bytes.
  - Data words D = (wc+3)>>2.
- **PAYLOAD:**
  - Each `word_enable` increments index i.
  - For i < D: `payload_valid`=1, `payload_data`=`word_in`.
    - `payload_keep` bit b = (4i+b < wc).
    - `payload_last` = (i == D−1).
  - Words with i ≥ D carry CRC only and are consumed silently.
  - When i == T−1 is consumed: pulse `packet_done`, go to DRAIN.
  - wc=0: D=0, T=1; no payload strobes.
- **DRAIN:** wait for `word_frame`=0, then go to IDLE.
- **Abort:** `word_frame` falling in HEADER or PAYLOAD pulses `pkt_error`, suppresses `payload_last` and `packet_done`, and returns to IDLE.
- `word_enable` while in IDLE or DRAIN is ignored.

## Timing
- All outputs are registered: one cycle latency from the accepting `word_enable` edge to the corresponding pulse or strobe.
- Every pulse output is exactly one cycle wide.
- `wait_for_sync`:
  - Rises the cycle after IDLE is entered.
  - Falls the cycle after `word_frame` rises.
- `packet_done` is guaranteed to occur before the combiner drops `word_frame`. The combiner's `word_frame` then falls one cycle after `packet_done`.
- Reset values: state IDLE; `wait_for_sync`=1; every other output 0, including `vc`, `dt`, `wc`, `payload_data`, `payload_keep`.
- Reset mid-packet: immediate return to IDLE, no `packet_done`, no `pkt_error`.
- `enable`=0 freezes state, counters and outputs. Pulses do not repeat when `enable` returns.

## Configuration
- `CSI_RX_ECC_CHECK_EN` defined:
  - HEADER computes the CSI-2 6-bit Hamming ECC over `word_in[23:0]` and compares it to `word_in[29:24]`.
  - On mismatch: pulse `pkt_error` and `packet_done`, no event or payload, go to DRAIN. This adds no extra latency.
- Not defined: `word_in[31:24]` is ignored and no ECC logic is present.

## Test plan
- Header 0x00000000 (FS, vc0, ECC 0) -> `frame_start` and `packet_done` pulse one cycle after the word; `wait_for_sync` is 0 during the packet and back to 1 after `word_frame` falls.
- Long packet dt=0x2A, wc=6 (T=2, D=2), words A,B -> `payload_valid` twice with keep 4'hF then 4'h3; `payload_last` on word B; `packet_done` with word B.
- Long packet dt=0x2A, wc=4 (T=2, D=1) -> one payload word, keep 4'hF, `payload_last` set; the CRC-only second word produces no strobe; `packet_done` after the second word.
- `word_frame` dropped after 1 of 3 payload words -> `pkt_error` pulse, no `packet_done`, state returns to IDLE, `wait_for_sync`=1.
- With `CSI_RX_ECC_CHECK_EN` defined, header 0x00000100 (ECC field 0, mismatched) -> `pkt_error` and `packet_done` pulse, no `frame_start`.
- Reset asserted mid-PAYLOAD -> next cycle `wait_for_sync`=1 and all other outputs 0.
